// File: rtl/rmac_sched_pkg.sv
// Shared definitions for the rmac scheduler: FSM state encoding and
// Q12.20 fixed-point reference constants.
package rmac_sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_RUN  = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Q12.20 format description and handy constants.
  localparam int          Q_INT     = 12;
  localparam int          Q_FRAC    = 20;
  localparam logic [31:0] Q_ONE     = 32'h0010_0000;  //  1.0
  localparam logic [31:0] Q_HALF    = 32'h0008_0000;  //  0.5
  localparam logic [31:0] Q_NEG_ONE = 32'hFFF0_0000;  // -1.0

endpackage : rmac_sched_pkg

// File: rtl/rmac_sched_arb.sv
// Two-way round-robin arbiter: a lone requester wins outright, a tie goes
// to the neuron that was not served last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  // Pick the winner from the current request vector and the last winner.
  always_comb begin
    grant = last;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = last;
    endcase
  end

endmodule : rr_arb2

// File: rtl/rmac_sched.sv
// Round-robin scheduler sharing one Q12.20 MAC between two neurons. Each
// granted request clears the accumulator, streams N weight/input pairs from
// the synchronous operand memory, waits out the MAC latency, captures the
// sum and pulses done for the requester.
module rmac_sched
  import rmac_sched_pkg::*;
#(
  parameter int N       = 8,
  parameter int WIDTH   = 32,
  parameter int INT     = 12,
  parameter int FRAC    = 20,
  parameter int AW      = 4,
  parameter int BASE0   = 0,
  parameter int BASE1   = 8,
  parameter int MAC_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             grant,
  output logic             mem_rd,
  output logic [AW-1:0]    mem_addr,
  input  logic [WIDTH-1:0] mem_w,
  input  logic [WIDTH-1:0] mem_x,
  output logic [WIDTH-1:0] mac_w,
  output logic [WIDTH-1:0] mac_x,
  output logic             mac_clr,
  output logic             mac_en,
  output logic             mac_last,
  input  logic [WIDTH-1:0] mac_sum
);

  // Parameter sanity: the fixed-point split must cover the word exactly.
  if (INT + FRAC != WIDTH) begin : g_bad_format
    $error("rmac_sched: INT + FRAC must equal WIDTH");
  end
  if (MAC_LAT < 1) begin : g_bad_latency
    $error("rmac_sched: MAC_LAT must be at least 1");
  end

  localparam int CNT_W = $clog2(N + 1);
  localparam int LAT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  // Region bases truncated to the address width so BASE+i wraps naturally.
  localparam logic [AW-1:0]    BASE0_A = AW'(BASE0);
  localparam logic [AW-1:0]    BASE1_A = AW'(BASE1);
  localparam logic [CNT_W-1:0] N_C     = CNT_W'(N);
  localparam logic [CNT_W-1:0] N_LAST  = CNT_W'(N - 1);
  localparam logic [LAT_W-1:0] LAT_END = LAT_W'(MAC_LAT - 1);

  state_e             state_q,    state_d;
  logic               grant_q,    grant_d;
  logic               last_q,     last_d;
  logic [CNT_W-1:0]   rd_cnt_q,   rd_cnt_d;
  logic [CNT_W-1:0]   en_cnt_q,   en_cnt_d;
  logic [LAT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [WIDTH-1:0]   result_q,   result_d;

  logic               arb_grant;
  logic [AW-1:0]      base;

  rr_arb2 u_arb (
    .req   (req),
    .last  (last_q),
    .grant (arb_grant)
  );

  // Operand region of the neuron currently being served.
  assign base = grant_q ? BASE1_A : BASE0_A;

  // Next-state, counter and output decode for the scheduler FSM.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    rd_cnt_d   = rd_cnt_q;
    en_cnt_d   = en_cnt_q;
    wait_cnt_d = wait_cnt_q;
    result_d   = result_q;
    done       = 2'b00;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;
    mac_last   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          grant_d = arb_grant;
          state_d = ST_CLR;
        end
      end

      ST_CLR: begin
        mac_clr  = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = base;
        rd_cnt_d = CNT_W'(1);
        en_cnt_d = '0;
        state_d  = ST_RUN;
      end

      ST_RUN: begin
        // Each cycle consumes the previous cycle's read and issues the next.
        mac_en = 1'b1;
        if (rd_cnt_q < N_C) begin
          mem_rd   = 1'b1;
          mem_addr = base + AW'(rd_cnt_q);
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
        if (en_cnt_q == N_LAST) begin
          mac_last   = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_WAIT;
        end else begin
          en_cnt_d = en_cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT: begin
        if (wait_cnt_q == LAT_END) begin
          result_d = mac_sum;
          state_d  = ST_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + LAT_W'(1);
        end
      end

      ST_DONE: begin
        done[grant_q] = 1'b1;
        last_d        = grant_q;
        state_d       = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      rd_cnt_q   <= '0;
      en_cnt_q   <= '0;
      wait_cnt_q <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      rd_cnt_q   <= rd_cnt_d;
      en_cnt_q   <= en_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      result_q   <= result_d;
    end
  end

  // Operands are gated to zero outside accumulate cycles.
  assign mac_w  = mac_en ? mem_w : '0;
  assign mac_x  = mac_en ? mem_x : '0;
  assign result = result_q;
  assign grant  = grant_q;
  assign busy   = (state_q != ST_IDLE);

endmodule : rmac_sched

// File: tb/tb_rmac_sched.sv
// Directed bench for rmac_sched: operand memory and Q12.20 MAC models feed
// the default build; a second MAC_LAT=3 build gets a bench-driven mac_sum.
module tb_rmac_sched;
  import rmac_sched_pkg::*;

  localparam int WIDTH = 32;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req = 2'b00;
  logic [1:0]       done;
  logic [WIDTH-1:0] result;
  logic             busy, grant, mem_rd, mac_clr, mac_en, mac_last;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_w, mem_x, mac_w, mac_x, mac_sum;

  // Second build with a longer MAC latency.
  logic [1:0]       l3_req = 2'b00;
  logic [1:0]       l3_done;
  logic [WIDTH-1:0] l3_result, l3_mac_w, l3_mac_x;
  logic             l3_busy, l3_grant, l3_mem_rd, l3_mac_clr, l3_mac_en, l3_mac_last;
  logic [AW-1:0]    l3_mem_addr;
  logic [WIDTH-1:0] l3_sum = 32'h0000_0000;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] w_mem [16];
  logic [WIDTH-1:0] x_mem [16];
  logic [WIDTH-1:0] acc;

  always #5 clk = ~clk;

  rmac_sched dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done), .result(result),
    .busy(busy), .grant(grant), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_w(mem_w), .mem_x(mem_x), .mac_w(mac_w), .mac_x(mac_x),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_last(mac_last), .mac_sum(mac_sum)
  );

  rmac_sched #(.MAC_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(l3_req), .done(l3_done), .result(l3_result),
    .busy(l3_busy), .grant(l3_grant), .mem_rd(l3_mem_rd), .mem_addr(l3_mem_addr),
    .mem_w(32'h0000_0000), .mem_x(32'h0000_0000), .mac_w(l3_mac_w), .mac_x(l3_mac_x),
    .mac_clr(l3_mac_clr), .mac_en(l3_mac_en), .mac_last(l3_mac_last), .mac_sum(l3_sum)
  );

  function automatic logic [31:0] qmul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    return p[51:20];
  endfunction

  // Synchronous operand memory: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_w <= w_mem[mem_addr];
      mem_x <= x_mem[mem_addr];
    end
  end

  // Single-cycle-latency Q12.20 accumulator.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       acc <= '0;
    else if (mac_clr) acc <= '0;
    else if (mac_en)  acc <= acc + qmul(mac_w, mac_x);
  end
  assign mac_sum = acc;

  // Free-running pattern for the latency-3 build's mac_sum.
  always @(posedge clk) l3_sum <= l3_sum + 32'h0001_1111;

  // Trace of one operation of the default build.
  int            cap_clr, cap_en, cap_nlast, cap_last_en, cap_done, cap_nrd, cap_leak;
  logic [1:0]    cap_done_val, cap_done_or;
  logic          cap_grant, cap_busy_clr;
  logic [AW-1:0] cap_addr [16];

  task automatic load_region(input int base, input logic [31:0] w, input logic [31:0] x);
    for (int i = 0; i < 8; i++) begin
      w_mem[(base + i) % 16] = w;
      x_mem[(base + i) % 16] = x;
    end
  endtask

  task automatic capture_op(input bit drop);
    cap_clr = -1; cap_en = 0; cap_nlast = 0; cap_last_en = -1; cap_done = -1;
    cap_nrd = 0; cap_leak = 0; cap_done_val = 2'b00; cap_done_or = 2'b00;
    cap_grant = 1'b0; cap_busy_clr = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mac_clr && cap_clr < 0) begin
        cap_clr = k;
        cap_busy_clr = busy;
      end
      if (mem_rd) begin
        if (cap_nrd < 16) cap_addr[cap_nrd] = mem_addr;
        cap_nrd++;
      end
      if (mac_en) cap_en++;
      if (mac_last) begin
        cap_nlast++;
        cap_last_en = cap_en;
      end
      if (!mac_en && (mac_w != '0 || mac_x != '0)) cap_leak++;
      cap_done_or |= done;
      if (done != 2'b00) begin
        cap_done = k;
        cap_done_val = done;
        cap_grant = grant;
        if (drop) req = req & ~done;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({done, busy, grant, mem_rd, mac_clr, mac_en, mac_last} !== 8'h00 ||
        mem_addr !== 4'h0 || result !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: done=%b busy=%b grant=%b rd=%b clr=%b en=%b last=%b addr=%h result=%h, need all zero",
               done, busy, grant, mem_rd, mac_clr, mac_en, mac_last, mem_addr, result);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single0;
    load_region(0, Q_ONE, Q_ONE);
    req = 2'b01;
    capture_op(1'b1);
    total++;
    if (cap_clr != 1 || cap_done != 11) begin
      bad++;
      $display("FAIL single0_timing: clr at %0d done at %0d, need 1 and 11", cap_clr, cap_done);
    end
    total++;
    if (cap_en != 8 || cap_nlast != 1 || cap_last_en != 8) begin
      bad++;
      $display("FAIL single0_en: mac_en=%0d last_count=%0d last_with_en=%0d, need 8 1 8",
               cap_en, cap_nlast, cap_last_en);
    end
    total++;
    if (cap_nrd != 8) begin
      bad++;
      $display("FAIL single0_reads: got %0d reads, need 8", cap_nrd);
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (cap_addr[i] !== 4'(i)) begin
          bad++;
          $display("FAIL single0_addr%0d: got %h need %h", i, cap_addr[i], 4'(i));
        end
      end
    end
    total++;
    if (cap_done_val !== 2'b01 || result !== 32'h0080_0000) begin
      bad++;
      $display("FAIL single0_result: done=%b result=%h, need 01 00800000", cap_done_val, result);
    end
    total++;
    if (cap_leak != 0 || cap_busy_clr !== 1'b1) begin
      bad++;
      $display("FAIL single0_gating: leak cycles=%0d busy_at_clr=%b, need 0 1", cap_leak, cap_busy_clr);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 2'b00 || result !== 32'h0080_0000) begin
      bad++;
      $display("FAIL single0_idle: busy=%b done=%b result=%h, need 0 00 00800000", busy, done, result);
    end
  endtask

  task automatic test_single1;
    load_region(8, Q_HALF, Q_ONE);
    req = 2'b10;
    capture_op(1'b1);
    total++;
    if (cap_grant !== 1'b1 || cap_done_val !== 2'b10 || cap_done_or !== 2'b10) begin
      bad++;
      $display("FAIL single1_grant: grant=%b done=%b any_done=%b, need 1 10 10",
               cap_grant, cap_done_val, cap_done_or);
    end
    total++;
    if (cap_nrd != 8 || cap_addr[0] !== 4'h8 || cap_addr[7] !== 4'hF) begin
      bad++;
      $display("FAIL single1_addr: reads=%0d first=%h last=%h, need 8 8 f",
               cap_nrd, cap_addr[0], cap_addr[7]);
    end
    total++;
    if (result !== 32'h0040_0000 || cap_done != 11) begin
      bad++;
      $display("FAIL single1_result: result=%h done at %0d, need 00400000 11", result, cap_done);
    end
    repeat (2) @(negedge clk);
    total++;
    if (grant !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single1_hold: idle grant=%b busy=%b, need 1 0", grant, busy);
    end
  endtask

  task automatic test_back_to_back;
    logic prev;
    load_region(0, Q_ONE, Q_ONE);
    load_region(8, Q_HALF, Q_ONE);
    prev = 1'b1;
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      capture_op(1'b0);
      if (i == 3) req = 2'b00;
      total++;
      if (cap_grant !== 1'(i % 2) || cap_done_val !== ((i % 2) ? 2'b10 : 2'b01)) begin
        bad++;
        $display("FAIL fair_grant%0d: grant=%b done=%b, need %0d", i, cap_grant, cap_done_val, i % 2);
      end
      total++;
      if (result !== ((i % 2) ? 32'h0040_0000 : 32'h0080_0000) || cap_done - cap_clr != 10) begin
        bad++;
        $display("FAIL fair_result%0d: result=%h clr_to_done=%0d, need %h 10", i, result,
                 cap_done - cap_clr, (i % 2) ? 32'h0040_0000 : 32'h0080_0000);
      end
      total++;
      if (cap_grant === prev) begin
        bad++;
        $display("FAIL fair_alternate%0d: grant %b repeated", i, cap_grant);
      end
      prev = cap_grant;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_negative;
    load_region(0, Q_NEG_ONE, Q_ONE);
    req = 2'b01;
    capture_op(1'b1);
    total++;
    if (result !== 32'hFF80_0000 || cap_done_val !== 2'b01) begin
      bad++;
      $display("FAIL negative_result: result=%h done=%b, need ff800000 01", result, cap_done_val);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int seen;
    load_region(0, Q_ONE, Q_ONE);
    req = 2'b01;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    req = 2'b00;
    #1;
    total++;
    if ({done, busy, grant, mem_rd, mac_clr, mac_en, mac_last} !== 8'h00 ||
        mem_addr !== 4'h0 || result !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_outputs: done=%b busy=%b rd=%b en=%b last=%b addr=%h result=%h, need all zero",
               done, busy, mem_rd, mac_en, mac_last, mem_addr, result);
    end
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      if (done != 2'b00) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL reset_mid_nodone: %0d done cycles after abort, need 0", seen);
    end
    req = 2'b01;
    capture_op(1'b1);
    total++;
    if (cap_clr != 1 || cap_done != 11 || cap_en != 8 || result !== 32'h0080_0000) begin
      bad++;
      $display("FAIL reset_mid_fresh: clr=%0d done=%0d en=%0d result=%h, need 1 11 8 00800000",
               cap_clr, cap_done, cap_en, result);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mac_lat3;
    logic [31:0] exp_sum;
    int done_k, en;
    exp_sum = 32'hxxxx_xxxx;
    done_k = -1;
    en = 0;
    l3_req = 2'b01;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 12) exp_sum = l3_sum;
      if (l3_mac_en) en++;
      if (l3_done != 2'b00) begin
        done_k = k;
        l3_req = 2'b00;
        break;
      end
    end
    total++;
    if (done_k != 13 || en != 8) begin
      bad++;
      $display("FAIL lat3_timing: done at %0d mac_en=%0d, need 13 8", done_k, en);
    end
    total++;
    if (l3_result !== exp_sum) begin
      bad++;
      $display("FAIL lat3_result: result=%h need %h", l3_result, exp_sum);
    end
    l3_req = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single0();
    test_single1();
    test_back_to_back();
    test_negative();
    test_mac_lat3();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_rmac_sched

// File: doc/rmac_sched.md
Name: rmac_sched

Overview:
- Round-robin scheduler that shares one Q12.20 multiply-accumulate datapath (rmac) between the two neurons.
- Per granted request it:
  - streams N weight/input pairs from a synchronous operand memory into the MAC;
  - waits out the MAC latency;
  - captures the sum and returns it to the requesting neuron with a one-cycle done pulse.
- Sits between the neuron control logic and the shared rmac/operand memory.

Parameters:
N, 8, number of weight/input pairs per dot product
WIDTH, 32, data width of W, X, sum
INT, 12, integer bits of fixed-point format (documentation and elaboration check only; INT+FRAC must equal WIDTH)
FRAC, 20, fractional bits
AW, 4, operand memory address width
BASE0, 0, first operand address for neuron 0
BASE1, 8, first operand address for neuron 1
MAC_LAT, 1, cycles from last mac_en to valid mac_sum (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  2  req[i]: neuron i requests a dot product; held until done[i]
done  out  2  one-cycle pulse; result valid for that neuron
result  out  WIDTH  captured sum; held until next capture
busy  out  1  high in every state except IDLE
grant  out  1  index of neuron being served; holds its value in IDLE
mem_rd  out  1  operand read strobe
mem_addr  out  AW  operand read address
mem_w  in  WIDTH  weight read data; valid the cycle after mem_rd
mem_x  in  WIDTH  input read data; valid the cycle after mem_rd
mac_w  out  WIDTH  weight to MAC; equals mem_w when mac_en is high, else 0
mac_x  out  WIDTH  input to MAC; equals mem_x when mac_en is high, else 0
mac_clr  out  1  clear accumulator, one cycle per operation
mac_en  out  1  accumulate mac_w*mac_x this cycle
mac_last  out  1  high with the final mac_en of an operation (rmac finished input)
mac_sum  in  WIDTH  MAC accumulator output

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - Outputs: done=0, result=0, busy=0, grant=0, mem_rd=0, mem_addr=0, mac_clr=0, mac_en=0, mac_last=0.
  - Round-robin pointer last=1, so neuron 0 wins the first tie.
  - Reset mid-operation aborts the operation: no done pulse, result cleared.
- States: IDLE, CLR, RUN, WAIT, DONE.
- IDLE:
  - If req!=0, pick grant: the single requester, or on a tie the neuron !=last.
  - Register grant and go to CLR. req is sampled in IDLE only.
- CLR (1 cycle):
  - mac_clr=1.
  - mem_rd=1, mem_addr=BASE[grant].
  - Term counter rd_cnt=1, en_cnt=0.
- RUN:
  - mac_en=1 every cycle, fed from the previous cycle's read data.
  - While rd_cnt<N: mem_rd=1, mem_addr=BASE[grant]+rd_cnt, rd_cnt++.
  - mac_last=1 when en_cnt==N-1.
  - After the Nth mac_en, go to WAIT. RUN lasts exactly N cycles.
- WAIT:
  - MAC_LAT cycles.
  - On the final WAIT cycle, result<=mac_sum.
- DONE (1 cycle):
  - done[grant]=1, last<=grant, then IDLE.
  - req is not sampled in DONE. The requester drops req on the edge after seeing done.
- Timing, with IDLE sampling req at cycle T:
  - CLR at T+1.
  - mac_en at T+2..T+N+1.
  - WAIT at T+N+2..T+N+1+MAC_LAT.
  - done at T+N+2+MAC_LAT.
  - Defaults: 11 cycles per op.
- Addresses:
  - BASE+i wraps modulo 2^AW.
  - No overlap check between BASE0 and BASE1 regions.
- Protocol violations:
  - req dropped mid-operation: the operation completes and done still pulses.
  - A req raised during an operation waits for IDLE.
- Fairness: with both req permanently high, grants strictly alternate 0,1,0,1.
- Arithmetic: the scheduler does no arithmetic on data. mac_sum is passed through unmodified as Q(INT).(FRAC).

Decomposition:
- Shared package: state encoding (IDLE, CLR, RUN, WAIT, DONE) and Q12.20 constants, e.g. ONE=32'h0010_0000.
- One natural sub-module, rr_arb2: 2-way round-robin arbiter. Inputs req, last. Output grant.

Test Plan:
- req=01, memory at 0..7 holds W=1.0, X=1.0 (32'h0010_0000), with the rmac model → mac_clr at T+1; mem_addr 0..7; exactly 8 mac_en; mac_last with the 8th; done=01 at T+11; result=32'h0080_0000 (8.0).
- req=11 held, BASE1 region holds W=0.5, X=1.0 → serviced order 0,1,0,1; neuron 1 result=32'h0040_0000 (4.0); no back-to-back grants to the same neuron.
- req=10 only → grant=1, mem_addr 8..15, done=10, done[0] never pulses.
- rst_n low at T+5 mid-RUN → all outputs 0 immediately; no done; after release with req=01 a fresh full 11-cycle op runs.
- MAC_LAT=3 build → done at T+13; result equals mac_sum sampled on the third WAIT cycle.
- Negative operands W=-1.0 (32'hFFF0_0000), X=1.0 ×8 → result=32'hFF80_0000 passed through unchanged.
